// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB first, parity bit, stop bit.
// Flags a one-cycle mismatch when the supplied even parity disagrees with the data word.
module parity_frame_tx #(
  parameter int DATA_W       = 3,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data,
  input  logic              even_p,
  output logic              tx,
  output logic              busy,
  output logic              frame_done,
  output logic              par_mismatch
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  state_e              state_r, state_n_s;
  logic [CNT_W-1:0]    cnt_r, cnt_n_s;
  logic [BIT_W-1:0]    bit_r, bit_n_s;
  logic [DATA_W-1:0]   shift_r, shift_n_s;
  logic                par_r, par_n_s;
  logic                accept_s;
  logic                wrap_s;
  logic                tx_n_s;
  logic                done_n_s;

  assign accept_s = in_valid && in_ready;
  assign wrap_s   = (cnt_r == LAST_CNT);

  // Next-state, counters, shift register and the next value of every registered output
  always_comb begin
    state_n_s = state_r;
    cnt_n_s   = cnt_r;
    bit_n_s   = bit_r;
    shift_n_s = shift_r;
    par_n_s   = par_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_n_s = START;
          cnt_n_s   = {CNT_W{1'b0}};
          bit_n_s   = {BIT_W{1'b0}};
          shift_n_s = data;
          par_n_s   = even_p;
        end else begin
          state_n_s = IDLE;
        end
      end
      START, PARITY, STOP: begin
        if (wrap_s) begin
          cnt_n_s = {CNT_W{1'b0}};
          if (state_r == START) begin
            state_n_s = DATA;
          end else if (state_r == PARITY) begin
            state_n_s = STOP;
          end else begin
            state_n_s = IDLE;
          end
        end else begin
          cnt_n_s = cnt_r + CNT_W'(1);
        end
      end
      DATA: begin
        if (wrap_s) begin
          cnt_n_s   = {CNT_W{1'b0}};
          shift_n_s = shift_r >> 1;
          if (bit_r == LAST_BIT) begin
            state_n_s = PARITY;
          end else begin
            bit_n_s = bit_r + BIT_W'(1);
          end
        end else begin
          cnt_n_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_n_s = IDLE;
        cnt_n_s   = {CNT_W{1'b0}};
        bit_n_s   = {BIT_W{1'b0}};
        shift_n_s = {DATA_W{1'b0}};
        par_n_s   = 1'b0;
      end
    endcase

    // Outputs are computed from the next state so that the registered line tracks the state
    case (state_n_s)
      START:   tx_n_s = 1'b0;
      DATA:    tx_n_s = shift_n_s[0];
      PARITY:  tx_n_s = par_n_s;
      default: tx_n_s = 1'b1;
    endcase
    done_n_s = (state_n_s == STOP) && (cnt_n_s == LAST_CNT);
  end

  // State, datapath and registered output flops with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      bit_r        <= {BIT_W{1'b0}};
      shift_r      <= {DATA_W{1'b0}};
      par_r        <= 1'b0;
      tx           <= 1'b1;
      in_ready     <= 1'b1;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      par_mismatch <= 1'b0;
    end else begin
      state_r      <= state_n_s;
      cnt_r        <= cnt_n_s;
      bit_r        <= bit_n_s;
      shift_r      <= shift_n_s;
      par_r        <= par_n_s;
      tx           <= tx_n_s;
      in_ready     <= (state_n_s == IDLE);
      busy         <= (state_n_s != IDLE);
      frame_done   <= done_n_s;
      par_mismatch <= accept_s && (even_parity(data) != even_p);
    end
  end

endmodule
